// File: rtl/jump_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : jump_ctrl_seq_if
// Purpose  : Instruction-register inputs and datapath control strobes of the
//            jump/branch control-step sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface jump_ctrl_seq_if #(
    parameter int IR_WIDTH = 32
);
    logic                Run;
    logic [IR_WIDTH-1:0] IR;
    logic                CON_FF;

    logic PCout, MAR_enable, IncPC, ZLowIn, ZLowout, PC_enable;
    logic MDR_read, MDR_enable, MDRout, IR_enable;
    logic Gra, R_out, R_in, Link_sel;
    logic CON_enable, Y_enable, Cout, ALU_add;
    logic [3:0] step;
    logic instr_done, halted, illegal;

    modport slave (
        input  Run, IR, CON_FF,
        output PCout, MAR_enable, IncPC, ZLowIn, ZLowout, PC_enable,
        output MDR_read, MDR_enable, MDRout, IR_enable,
        output Gra, R_out, R_in, Link_sel,
        output CON_enable, Y_enable, Cout, ALU_add,
        output step, instr_done, halted, illegal
    );

    modport master (
        output Run, IR, CON_FF,
        input  PCout, MAR_enable, IncPC, ZLowIn, ZLowout, PC_enable,
        input  MDR_read, MDR_enable, MDRout, IR_enable,
        input  Gra, R_out, R_in, Link_sel,
        input  CON_enable, Y_enable, Cout, ALU_add,
        input  step, instr_done, halted, illegal
    );
endinterface
`default_nettype wire

// File: rtl/jump_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : jump_ctrl_seq
// Purpose  : Hardwired control-step sequencer: fetch with memory wait states,
//            then jr / jal / br / nop / halt execution and illegal trapping.
// Revision : 1.0 - initial release
// ============================================================================
module jump_ctrl_seq #(
    parameter int          IR_WIDTH = 32,
    parameter int          MEM_WAIT = 0,
    parameter logic [4:0]  OP_BR    = 5'b10011,
    parameter logic [4:0]  OP_JR    = 5'b10100,
    parameter logic [4:0]  OP_JAL   = 5'b10101,
    parameter logic [4:0]  OP_NOP   = 5'b11010,
    parameter logic [4:0]  OP_HALT  = 5'b11011
) (
    input  wire logic Clock,
    input  wire logic Clear,
    jump_ctrl_seq_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_WAIT = 4'd3,
        S_T2   = 4'd4,
        S_T3   = 4'd5,
        S_T4   = 4'd6,
        S_T5   = 4'd7,
        S_T6   = 4'd8,
        S_HALT = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        K_NONE = 2'd0,
        K_JAL  = 2'd1,
        K_BR   = 2'd2
    } kind_t;

    localparam logic [3:0] c_WAIT_LAST = 4'(MEM_WAIT - 1);

    // Bit positions inside the strobe vector
    localparam int c_PCOUT = 17, c_MARE = 16, c_INCPC = 15, c_ZLI  = 14;
    localparam int c_ZLO   = 13, c_PCE  = 12, c_MDRR  = 11, c_MDRE = 10;
    localparam int c_MDROUT = 9, c_IRE  = 8,  c_GRA   = 7,  c_ROUT = 6;
    localparam int c_RIN   = 5,  c_LINK = 4,  c_CONE  = 3,  c_YE   = 2;
    localparam int c_COUT  = 1,  c_ADD  = 0;

    state_t     state_q, state_d;
    kind_t      kind_q,  kind_d;
    logic [3:0] wait_q,  wait_d;
    logic       illegal_q, illegal_d;

    logic [4:0]  w_opcode;
    logic        w_unused_ir;
    state_t      w_end_state;
    logic [17:0] w_str;
    logic        w_done;

    assign w_opcode    = bus.IR[IR_WIDTH-1 -: 5];
    assign w_unused_ir = ^bus.IR[IR_WIDTH-6:0];
    assign w_end_state = bus.Run ? S_T0 : S_IDLE;

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: if (bus.Run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1: begin
                wait_d  = '0;
                state_d = (MEM_WAIT == 0) ? S_T2 : S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == c_WAIT_LAST) state_d = S_T2;
                else                       wait_d  = wait_q + 4'd1;
            end
            S_T2:   state_d = S_T3;
            S_T3: begin
                kind_d = K_NONE;
                case (w_opcode)
                    OP_JR, OP_NOP: state_d = w_end_state;
                    OP_JAL: begin state_d = S_T4; kind_d = K_JAL; end
                    OP_BR:  begin state_d = S_T4; kind_d = K_BR;  end
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_T4:   state_d = (kind_q == K_JAL) ? w_end_state : S_T5;
            S_T5:   state_d = S_T6;
            S_T6:   state_d = w_end_state;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q   <= S_IDLE;
            kind_q    <= K_NONE;
            wait_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes are decoded from the registered step; T3 looks at the freshly
    // loaded IR and T6 passes the branch condition straight to PC_enable.
    always_comb begin
        w_str  = '0;
        w_done = 1'b0;
        case (state_q)
            S_T0: begin
                w_str[c_PCOUT] = 1'b1; w_str[c_MARE] = 1'b1;
                w_str[c_INCPC] = 1'b1; w_str[c_ZLI]  = 1'b1;
            end
            S_T1: begin
                w_str[c_ZLO]  = 1'b1; w_str[c_PCE]  = 1'b1;
                w_str[c_MDRR] = 1'b1; w_str[c_MDRE] = 1'b1;
            end
            S_WAIT: begin
                w_str[c_MDRR] = 1'b1; w_str[c_MDRE] = 1'b1;
            end
            S_T2: begin
                w_str[c_MDROUT] = 1'b1; w_str[c_IRE] = 1'b1;
            end
            S_T3: begin
                case (w_opcode)
                    OP_JR: begin
                        w_str[c_GRA] = 1'b1; w_str[c_ROUT] = 1'b1;
                        w_str[c_PCE] = 1'b1; w_done = 1'b1;
                    end
                    OP_JAL: begin
                        w_str[c_PCOUT] = 1'b1; w_str[c_RIN] = 1'b1;
                        w_str[c_LINK]  = 1'b1;
                    end
                    OP_BR: begin
                        w_str[c_GRA]  = 1'b1; w_str[c_ROUT] = 1'b1;
                        w_str[c_CONE] = 1'b1;
                    end
                    OP_NOP, OP_HALT: w_done = 1'b1;
                    default: w_done = 1'b0;
                endcase
            end
            S_T4: begin
                if (kind_q == K_JAL) begin
                    w_str[c_GRA] = 1'b1; w_str[c_ROUT] = 1'b1;
                    w_str[c_PCE] = 1'b1; w_done = 1'b1;
                end else begin
                    w_str[c_PCOUT] = 1'b1; w_str[c_YE] = 1'b1;
                end
            end
            S_T5: begin
                w_str[c_COUT] = 1'b1; w_str[c_ADD] = 1'b1;
                w_str[c_ZLI]  = 1'b1;
            end
            S_T6: begin
                w_str[c_ZLO] = 1'b1;
                w_str[c_PCE] = bus.CON_FF;
                w_done       = 1'b1;
            end
            default: begin
                w_str  = '0;
                w_done = 1'b0;
            end
        endcase
    end

    assign bus.PCout      = w_str[c_PCOUT];
    assign bus.MAR_enable = w_str[c_MARE];
    assign bus.IncPC      = w_str[c_INCPC];
    assign bus.ZLowIn     = w_str[c_ZLI];
    assign bus.ZLowout    = w_str[c_ZLO];
    assign bus.PC_enable  = w_str[c_PCE];
    assign bus.MDR_read   = w_str[c_MDRR];
    assign bus.MDR_enable = w_str[c_MDRE];
    assign bus.MDRout     = w_str[c_MDROUT];
    assign bus.IR_enable  = w_str[c_IRE];
    assign bus.Gra        = w_str[c_GRA];
    assign bus.R_out      = w_str[c_ROUT];
    assign bus.R_in       = w_str[c_RIN];
    assign bus.Link_sel   = w_str[c_LINK];
    assign bus.CON_enable = w_str[c_CONE];
    assign bus.Y_enable   = w_str[c_YE];
    assign bus.Cout       = w_str[c_COUT];
    assign bus.ALU_add    = w_str[c_ADD];
    assign bus.step       = state_q;
    assign bus.instr_done = w_done;
    assign bus.halted     = (state_q == S_HALT);
    assign bus.illegal    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_jump_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jump_ctrl_seq
// Purpose  : Randomized check of two sequencers (MEM_WAIT=0 and 3) against a
//            per-instruction step-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jump_ctrl_seq;

    localparam int         c_NCYC = 4000;
    localparam logic [4:0] c_OP_BR = 5'b10011, c_OP_JR = 5'b10100, c_OP_JAL = 5'b10101;
    localparam logic [4:0] c_OP_NOP = 5'b11010, c_OP_HALT = 5'b11011;

    localparam int c_PCOUT = 17, c_MARE = 16, c_INCPC = 15, c_ZLI  = 14;
    localparam int c_ZLO   = 13, c_PCE  = 12, c_MDRR  = 11, c_MDRE = 10;
    localparam int c_MDROUT = 9, c_IRE  = 8,  c_GRA   = 7,  c_ROUT = 6;
    localparam int c_RIN   = 5,  c_LINK = 4,  c_CONE  = 3,  c_YE   = 2;
    localparam int c_COUT  = 1,  c_ADD  = 0;

    typedef struct packed {
        logic [3:0]  step;
        logic [17:0] str;
        logic        done;
        logic        pc_con;
        logic        set_ill;
    } rec_t;

    logic       clk = 1'b0;
    logic [1:0] clr;
    always #5 clk = ~clk;

    jump_ctrl_seq_if #(.IR_WIDTH(32)) b0 ();
    jump_ctrl_seq_if #(.IR_WIDTH(32)) b3 ();

    jump_ctrl_seq #(.IR_WIDTH(32), .MEM_WAIT(0)) u_dut0 (.Clock(clk), .Clear(clr[0]), .bus(b0.slave));
    jump_ctrl_seq #(.IR_WIDTH(32), .MEM_WAIT(3)) u_dut3 (.Clock(clk), .Clear(clr[1]), .bus(b3.slave));

    logic [24:0] obs [2];
    assign obs[0] = {b0.step, b0.halted, b0.illegal, b0.instr_done,
                     b0.PCout, b0.MAR_enable, b0.IncPC, b0.ZLowIn, b0.ZLowout, b0.PC_enable,
                     b0.MDR_read, b0.MDR_enable, b0.MDRout, b0.IR_enable,
                     b0.Gra, b0.R_out, b0.R_in, b0.Link_sel,
                     b0.CON_enable, b0.Y_enable, b0.Cout, b0.ALU_add};
    assign obs[1] = {b3.step, b3.halted, b3.illegal, b3.instr_done,
                     b3.PCout, b3.MAR_enable, b3.IncPC, b3.ZLowIn, b3.ZLowout, b3.PC_enable,
                     b3.MDR_read, b3.MDR_enable, b3.MDRout, b3.IR_enable,
                     b3.Gra, b3.R_out, b3.R_in, b3.Link_sel,
                     b3.CON_enable, b3.Y_enable, b3.Cout, b3.ALU_add};

    int          n_cmp = 0;
    int          n_bad = 0;
    int          mw [2] = '{0, 3};
    rec_t        cur [2];
    rec_t        pend [2][$];
    logic        ill [2];
    logic        con [2];
    logic [31:0] irv [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [17:0] bm(input int i);
        return 18'd1 << i;
    endfunction

    function automatic rec_t mk(input logic [3:0] s, input logic [17:0] m,
                                input logic d, input logic pc, input logic si);
        rec_t r;
        r.step = s; r.str = m; r.done = d; r.pc_con = pc; r.set_ill = si;
        return r;
    endfunction

    // Full step list for one instruction after T0, straight from the step table
    task automatic build(input int k, input logic [4:0] op);
        pend[k].push_back(mk(4'd2, bm(c_ZLO) | bm(c_PCE) | bm(c_MDRR) | bm(c_MDRE), 0, 0, 0));
        for (int i = 0; i < mw[k]; i++)
            pend[k].push_back(mk(4'd3, bm(c_MDRR) | bm(c_MDRE), 0, 0, 0));
        pend[k].push_back(mk(4'd4, bm(c_MDROUT) | bm(c_IRE), 0, 0, 0));
        case (op)
            c_OP_JR:  pend[k].push_back(mk(4'd5, bm(c_GRA) | bm(c_ROUT) | bm(c_PCE), 1, 0, 0));
            c_OP_JAL: begin
                pend[k].push_back(mk(4'd5, bm(c_PCOUT) | bm(c_RIN) | bm(c_LINK), 0, 0, 0));
                pend[k].push_back(mk(4'd6, bm(c_GRA) | bm(c_ROUT) | bm(c_PCE), 1, 0, 0));
            end
            c_OP_BR: begin
                pend[k].push_back(mk(4'd5, bm(c_GRA) | bm(c_ROUT) | bm(c_CONE), 0, 0, 0));
                pend[k].push_back(mk(4'd6, bm(c_PCOUT) | bm(c_YE), 0, 0, 0));
                pend[k].push_back(mk(4'd7, bm(c_COUT) | bm(c_ADD) | bm(c_ZLI), 0, 0, 0));
                pend[k].push_back(mk(4'd8, bm(c_ZLO), 1, 1, 0));
            end
            c_OP_NOP: pend[k].push_back(mk(4'd5, 18'd0, 1, 0, 0));
            c_OP_HALT: begin
                pend[k].push_back(mk(4'd5, 18'd0, 1, 0, 0));
                pend[k].push_back(mk(4'd15, 18'd0, 0, 0, 0));
            end
            default: begin
                pend[k].push_back(mk(4'd5, 18'd0, 0, 0, 0));
                pend[k].push_back(mk(4'd15, 18'd0, 0, 0, 1));
            end
        endcase
    endtask

    function automatic logic [4:0] pick_op();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1:    return c_OP_JR;
            2, 3:    return c_OP_JAL;
            4, 5, 6: return c_OP_BR;
            7:       return c_OP_NOP;
            8:       return c_OP_HALT;
            default: begin
                case ($urandom_range(0, 2))
                    0:       return 5'b11111;
                    1:       return 5'b00000;
                    default: return 5'b10110;
                endcase
            end
        endcase
    endfunction

    task automatic check(input int k);
        rec_t        e;
        logic [17:0] es;
        e  = cur[k];
        es = e.str | ((e.pc_con && con[k]) ? bm(c_PCE) : 18'd0);
        chk($sformatf("dut%0d step", mw[k]),    32'(obs[k][24:21]), 32'(e.step));
        chk($sformatf("dut%0d strobes", mw[k]), 32'(obs[k][17:0]),  32'(es));
        chk($sformatf("dut%0d halted/illegal/done", mw[k]), 32'(obs[k][20:18]),
            32'({e.step == 4'd15, ill[k], e.done}));
    endtask

    task automatic drive(input int k, input logic c, input logic rn);
        clr[k] = c;
        if (k == 0) begin
            b0.Run = rn; b0.CON_FF = con[k]; b0.IR = irv[k];
        end else begin
            b3.Run = rn; b3.CON_FF = con[k]; b3.IR = irv[k];
        end
    endtask

    task automatic advance(input int k);
        logic       c;
        logic       rn;
        logic [4:0] op;
        c      = ($urandom_range(0, 99) < ((cur[k].step == 4'd15) ? 30 : 2));
        rn     = ($urandom_range(0, 99) < 80);
        con[k] = 1'($urandom_range(0, 1));
        if (cur[k].step == 4'd1) begin
            op     = pick_op();
            irv[k] = {op, 27'($urandom)};
            build(k, op);
        end
        drive(k, c, rn);
        if (c) begin
            cur[k] = mk(4'd0, 18'd0, 0, 0, 0);
            pend[k].delete();
            ill[k] = 1'b0;
        end else if (pend[k].size() > 0) begin
            cur[k] = pend[k].pop_front();
            if (cur[k].set_ill) ill[k] = 1'b1;
        end else if (cur[k].step != 4'd15) begin
            cur[k] = rn ? mk(4'd1, bm(c_PCOUT) | bm(c_MARE) | bm(c_INCPC) | bm(c_ZLI), 0, 0, 0)
                        : mk(4'd0, 18'd0, 0, 0, 0);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            con[k] = 1'b0;
            irv[k] = 32'hA080_0000;
            ill[k] = 1'b0;
            cur[k] = mk(4'd0, 18'd0, 0, 0, 0);
            drive(k, 1'b1, 1'b0);
        end
        for (int n = 0; n < c_NCYC; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check(k);
                advance(k);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
